// File: rtl/arb_pkg.sv
// Shared types and the round-robin search function for the array arbiter.
// Widths are sized for the largest supported requester count (8).
package arb_pkg;

   localparam int MAX_REQ = 8;
   localparam int IDX_W   = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_ACK   = 2'd2
   } state_t;

   typedef struct packed {
      logic             valid;
      logic [IDX_W-1:0] idx;
   } pick_t;

   // Scan from ptr upward, wrapping at nreq; the first set request wins.
   function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                     input logic [IDX_W-1:0]   ptr,
                                     input int                 nreq);
      pick_t res;
      int    j;
      res = '0;
      for (int k = 0; k < MAX_REQ; k++) begin
         j = int'(ptr) + k;
         if (j >= nreq) j = j - nreq;
         if (k < nreq && !res.valid && req[3'(j)]) begin
            res.valid = 1'b1;
            res.idx   = 3'(j);
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational rotating-priority picker: returns a one-hot winner and a
// valid flag for the current request vector and round-robin pointer.
module rr_picker
   import arb_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   output logic             valid,
   output logic [NREQ-1:0]  onehot
);

   logic [MAX_REQ-1:0] req_ext;
   pick_t              pick;

   always_comb begin
      req_ext             = '0;
      req_ext[NREQ-1:0]   = req;
      pick                = rr_pick(req_ext, ptr, NREQ);
      valid               = pick.valid;
      onehot              = '0;
      if (pick.valid) onehot = NREQ'(1) << pick.idx;
   end

endmodule

// File: rtl/array_rr_arbiter.sv
// Shares one register array between NREQ requesters: round-robin pick in
// IDLE, single access in GRANT, one-cycle ack pulse in ACK.
module array_rr_arbiter
   import arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int DEPTH = 32,
   parameter int AW    = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ-1:0]       we,
   input  logic [NREQ*AW-1:0]    addr,
   input  logic [NREQ*WIDTH-1:0] wdata,
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       ack,
   output logic [WIDTH-1:0]      rdata,
   output logic                  busy
);

   logic [WIDTH-1:0] mem [DEPTH];

   state_t           state, state_nx;
   logic [IDX_W-1:0] ptr, ptr_nx;
   logic             win_valid;
   logic [NREQ-1:0]  win_oh;

   logic             we_sel, we_l;
   logic [AW-1:0]    addr_sel, addr_l;
   logic [WIDTH-1:0] wdata_sel, wdata_l;
   logic             in_range;

   rr_picker #(.NREQ(NREQ)) u_picker (
      .req    (req),
      .ptr    (ptr),
      .valid  (win_valid),
      .onehot (win_oh)
   );

   assign busy     = (state != ST_IDLE);
   assign in_range = (32'(addr_l) < 32'(DEPTH));

   // Mux the winner's transaction fields and the pointer that follows it.
   always_comb begin
      we_sel    = 1'b0;
      addr_sel  = '0;
      wdata_sel = '0;
      ptr_nx    = ptr;
      for (int i = 0; i < NREQ; i++) begin
         if (win_oh[i]) begin
            we_sel    = we[i];
            addr_sel  = addr[i*AW +: AW];
            wdata_sel = wdata[i*WIDTH +: WIDTH];
            ptr_nx    = (i == NREQ-1) ? '0 : IDX_W'(i + 1);
         end
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  if (win_valid) state_nx = ST_GRANT;
         ST_GRANT: state_nx = ST_ACK;
         ST_ACK:   state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   // gnt spans GRANT and ACK; ack copies gnt for the single ACK cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         ptr     <= '0;
         gnt     <= '0;
         ack     <= '0;
         rdata   <= '0;
         we_l    <= 1'b0;
         addr_l  <= '0;
         wdata_l <= '0;
      end else begin
         state <= state_nx;
         ack   <= '0;
         case (state)
            ST_IDLE: begin
               if (win_valid) begin
                  gnt     <= win_oh;
                  ptr     <= ptr_nx;
                  we_l    <= we_sel;
                  addr_l  <= addr_sel;
                  wdata_l <= wdata_sel;
               end
            end
            ST_GRANT: begin
               ack <= gnt;
               if (!we_l) rdata <= in_range ? mem[addr_l] : '0;
            end
            ST_ACK:  gnt <= '0;
            default: gnt <= '0;
         endcase
      end
   end

   // Array contents are deliberately not reset; out-of-range writes drop.
   always_ff @(posedge clk) begin
      if (state == ST_GRANT && we_l && in_range) mem[addr_l] <= wdata_l;
   end

endmodule

// File: tb/tb_array_rr_arbiter.sv
// Directed test of array_rr_arbiter: reset, read/write, round-robin order,
// pointer wrap, input stability after grant, out-of-range and async reset.
module tb_array_rr_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int DEPTH = 30;
   localparam int AW    = 5;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req, we;
   logic [NREQ*AW-1:0]    addr;
   logic [NREQ*WIDTH-1:0] wdata;
   logic [NREQ-1:0]       gnt, ack;
   logic [WIDTH-1:0]      rdata;
   logic                  busy;

   int checks = 0;
   int errors = 0;

   array_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .we    (we),
      .addr  (addr),
      .wdata (wdata),
      .gnt   (gnt),
      .ack   (ack),
      .rdata (rdata),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   task set_req(input int r, input logic w, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
      req[r]            = 1'b1;
      we[r]             = w;
      addr[r*AW +: AW]  = a;
      wdata[r*WIDTH +: WIDTH] = d;
   endtask

   // Bounded wait for any ack; cyc = -1 on timeout.
   task wait_ack(output int cyc, output logic [NREQ-1:0] a);
      cyc = 0;
      a   = '0;
      while (cyc < 12 && a == '0) begin
         @(posedge clk); #1;
         cyc++;
         a = ack;
      end
      if (a == '0) cyc = -1;
   endtask

   task run_txn(input int r, input logic w, input logic [AW-1:0] a, input logic [WIDTH-1:0] d,
                output int cyc, output logic [NREQ-1:0] a_seen, output logic [WIDTH-1:0] rd);
      set_req(r, w, a, d);
      wait_ack(cyc, a_seen);
      rd     = rdata;
      req[r] = 1'b0;
      @(posedge clk); #1;
   endtask

   task reset_dut;
      req = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task test_reset;
      logic [NREQ-1:0] a;
      req = '0; we = '0; addr = '0; wdata = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({gnt, ack, busy} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_hold: gnt=%b ack=%b busy=%b expected all 0", gnt, ack, busy);
      end
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         a = gnt | ack;
         checks++;
         if (a !== '0 || busy !== 1'b0 || rdata !== '0) begin
            errors++;
            $display("[TB] FAIL idle_%0d: gnt=%b ack=%b busy=%b rdata=%h expected 0", i, gnt, ack, busy, rdata);
         end
      end
   endtask

   task test_single_rw;
      int cyc; logic [NREQ-1:0] a; logic [WIDTH-1:0] rd;
      run_txn(0, 1'b1, 5'd5, 8'hA5, cyc, a, rd);
      checks++;
      if (cyc !== 2 || a !== 4'b0001) begin
         errors++;
         $display("[TB] FAIL write5: cyc=%0d ack=%b expected cyc=2 ack=0001", cyc, a);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL busy_after_write: got %b expected 0", busy);
      end
      run_txn(0, 1'b0, 5'd5, 8'h00, cyc, a, rd);
      checks++;
      if (cyc !== 2 || a !== 4'b0001 || rd !== 8'hA5) begin
         errors++;
         $display("[TB] FAIL read5: cyc=%0d ack=%b rdata=%h expected 2 0001 a5", cyc, a, rd);
      end
   endtask

   task test_round_robin;
      int cyc; logic [NREQ-1:0] a;
      int order [6] = '{0, 1, 2, 3, 0, 1};
      reset_dut();
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 5'd5, 8'h00);
      for (int n = 0; n < 6; n++) begin
         wait_ack(cyc, a);
         checks++;
         if (a !== 4'(1 << order[n]) || cyc !== ((n == 0) ? 2 : 3) || rdata !== 8'hA5) begin
            errors++;
            $display("[TB] FAIL rr_%0d: ack=%b cyc=%0d rdata=%h expected ack=%b cyc=%0d rdata=a5",
                     n, a, cyc, rdata, 4'(1 << order[n]), (n == 0) ? 2 : 3);
         end
      end
      req = '0;
      @(posedge clk); #1;
   endtask

   task test_pointer_wrap;
      int cyc; logic [NREQ-1:0] a; logic [WIDTH-1:0] rd;
      run_txn(2, 1'b0, 5'd5, 8'h00, cyc, a, rd);
      checks++;
      if (a !== 4'b0100) begin
         errors++;
         $display("[TB] FAIL wrap_setup: ack=%b expected 0100", a);
      end
      set_req(1, 1'b0, 5'd5, 8'h00);
      set_req(3, 1'b0, 5'd5, 8'h00);
      wait_ack(cyc, a);
      checks++;
      if (a !== 4'b1000 || cyc !== 2) begin
         errors++;
         $display("[TB] FAIL wrap_first: ack=%b cyc=%0d expected 1000 2", a, cyc);
      end
      req[3] = 1'b0;
      wait_ack(cyc, a);
      checks++;
      if (a !== 4'b0010 || cyc !== 3) begin
         errors++;
         $display("[TB] FAIL wrap_second: ack=%b cyc=%0d expected 0010 3", a, cyc);
      end
      req[1] = 1'b0;
      @(posedge clk); #1;
      set_req(0, 1'b0, 5'd5, 8'h00);
      set_req(2, 1'b0, 5'd5, 8'h00);
      wait_ack(cyc, a);
      checks++;
      if (a !== 4'b0100) begin
         errors++;
         $display("[TB] FAIL wrap_ptr2: ack=%b expected 0100", a);
      end
      req = '0;
      @(posedge clk); #1;
   endtask

   task test_input_change;
      int cyc; logic [NREQ-1:0] a; logic [WIDTH-1:0] rd;
      set_req(2, 1'b1, 5'd7, 8'h11);
      @(posedge clk); #1;
      checks++;
      if (gnt !== 4'b0100 || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL chg_grant: gnt=%b busy=%b expected 0100 1", gnt, busy);
      end
      addr[2*AW +: AW]        = 5'd5;
      wdata[2*WIDTH +: WIDTH] = 8'h22;
      we[2]                   = 1'b0;
      wait_ack(cyc, a);
      checks++;
      if (a !== 4'b0100 || cyc !== 1) begin
         errors++;
         $display("[TB] FAIL chg_ack: ack=%b cyc=%0d expected 0100 1", a, cyc);
      end
      req[2] = 1'b0;
      @(posedge clk); #1;
      run_txn(0, 1'b0, 5'd7, 8'h00, cyc, a, rd);
      checks++;
      if (rd !== 8'h11) begin
         errors++;
         $display("[TB] FAIL chg_read7: rdata=%h expected 11", rd);
      end
      run_txn(0, 1'b0, 5'd5, 8'h00, cyc, a, rd);
      checks++;
      if (rd !== 8'hA5) begin
         errors++;
         $display("[TB] FAIL chg_read5: rdata=%h expected a5", rd);
      end
   endtask

   task test_out_of_range;
      int cyc; logic [NREQ-1:0] a; logic [WIDTH-1:0] rd;
      run_txn(1, 1'b1, 5'd29, 8'h3C, cyc, a, rd);
      run_txn(1, 1'b1, 5'd30, 8'hFF, cyc, a, rd);
      checks++;
      if (a !== 4'b0010 || cyc !== 2) begin
         errors++;
         $display("[TB] FAIL oor_write_ack: ack=%b cyc=%0d expected 0010 2", a, cyc);
      end
      run_txn(1, 1'b0, 5'd29, 8'h00, cyc, a, rd);
      checks++;
      if (rd !== 8'h3C) begin
         errors++;
         $display("[TB] FAIL oor_read29: rdata=%h expected 3c", rd);
      end
      run_txn(1, 1'b0, 5'd30, 8'h00, cyc, a, rd);
      checks++;
      if (rd !== 8'h00 || a !== 4'b0010) begin
         errors++;
         $display("[TB] FAIL oor_read30: rdata=%h ack=%b expected 00 0010", rd, a);
      end
   endtask

   task test_reset_midop;
      int cyc; logic [NREQ-1:0] a; logic [WIDTH-1:0] rd;
      run_txn(1, 1'b1, 5'd9, 8'h00, cyc, a, rd);
      set_req(3, 1'b1, 5'd9, 8'h5A);
      @(posedge clk); #1;
      checks++;
      if (gnt !== 4'b1000 || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL mid_grant: gnt=%b busy=%b expected 1000 1", gnt, busy);
      end
      #1 rst = 1'b1;
      #1;
      checks++;
      if (gnt !== '0 || busy !== 1'b0 || ack !== '0) begin
         errors++;
         $display("[TB] FAIL mid_async_clear: gnt=%b busy=%b ack=%b expected 0", gnt, busy, ack);
      end
      req = '0;
      @(posedge clk); #1;
      checks++;
      if (ack !== '0 || gnt !== '0) begin
         errors++;
         $display("[TB] FAIL mid_no_ack: ack=%b gnt=%b expected 0", ack, gnt);
      end
      rst = 1'b0;
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 5'd9, 8'h00);
      wait_ack(cyc, a);
      checks++;
      if (a !== 4'b0001 || cyc !== 2 || rdata !== 8'h00) begin
         errors++;
         $display("[TB] FAIL mid_restart: ack=%b cyc=%0d rdata=%h expected 0001 2 00", a, cyc, rdata);
      end
      req = '0;
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_single_rw();
      test_round_robin();
      test_pointer_wrap();
      test_input_change();
      test_out_of_range();
      test_reset_midop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

endmodule
